// File: rtl/mp_memory_pkg.sv
// Shared types and helpers for the N-port scratch memory.
// Lane arbitration is written for up to MAX_PORTS ports.
package mp_memory_pkg;

   localparam int MAX_PORTS = 8;
   localparam int PORT_W    = 3;
   localparam int LANE_W    = 8;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      DONE
   } clr_state_t;

   typedef struct packed {
      logic              hit;
      logic              multi;
      logic [PORT_W-1:0] idx;
   } lane_pick_t;

   // req[q] = port q is an active writer of this byte lane at the address under test.
   // Walking downwards leaves the lowest requesting port as the winner.
   function automatic lane_pick_t pick_lane(input logic [MAX_PORTS-1:0] req);
      lane_pick_t pick;
      pick = '0;
      for (int q = MAX_PORTS - 1; q >= 0; q--) begin
         if (req[q]) begin
            pick.multi = pick.multi | pick.hit;
            pick.hit   = 1'b1;
            pick.idx   = PORT_W'(q);
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/mp_memory_wmerge.sv
// Combinational write merge: for each port's address, the per-lane winning write
// data, the mask of lanes written this cycle, and a flag for overlapping writers.
module mp_memory_wmerge
   import mp_memory_pkg::*;
#(
   parameter int DATA   = 8,
   parameter int ADDR   = 4,
   parameter int NPORTS = 2
) (
   input  logic [NPORTS-1:0]             act_wr,
   input  logic [NPORTS*(DATA/8)-1:0]    be,
   input  logic [NPORTS*ADDR-1:0]        addr,
   input  logic [NPORTS*DATA-1:0]        din,
   output logic [NPORTS*DATA-1:0]        merged,
   output logic [NPORTS*(DATA/8)-1:0]    mask,
   output logic                          conflict
);

   localparam int BYTES = DATA / LANE_W;

   logic [MAX_PORTS-1:0] req;
   lane_pick_t           pick;

   // Writers colliding on one address resolve identically from every port's view,
   // so every writer can commit its own merged word without disagreement.
   always_comb begin
      merged   = '0;
      mask     = '0;
      conflict = 1'b0;
      req      = '0;
      pick     = '0;
      for (int p = 0; p < NPORTS; p++) begin
         for (int b = 0; b < BYTES; b++) begin
            req = '0;
            for (int q = 0; q < NPORTS; q++) begin
               req[q] = act_wr[q] & be[q*BYTES + b]
                        & (addr[q*ADDR +: ADDR] == addr[p*ADDR +: ADDR]);
            end
            pick = pick_lane(req);
            mask[p*BYTES + b] = pick.hit;
            merged[p*DATA + b*LANE_W +: LANE_W] = din[int'(pick.idx)*DATA + b*LANE_W +: LANE_W];
            conflict = conflict | pick.multi;
         end
      end
   end

endmodule

// File: rtl/mp_memory.sv
// N-port byte-enabled scratch memory with write merge, conflict counting,
// selectable read-during-write behaviour, optional output register and clear engine.
module mp_memory
   import mp_memory_pkg::*;
#(
   parameter int DATA        = 8,
   parameter int ADDR        = 4,
   parameter int NPORTS      = 2,
   parameter int WRITE_FIRST = 1,
   parameter int OUT_REG     = 0,
   parameter int CNT_W       = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NPORTS-1:0]          en,
   input  logic [NPORTS-1:0]          wr,
   input  logic [NPORTS*(DATA/8)-1:0] be,
   input  logic [NPORTS*ADDR-1:0]     addr,
   input  logic [NPORTS*DATA-1:0]     din,
   output logic [NPORTS*DATA-1:0]     dout,
   output logic [NPORTS-1:0]          dvalid,
   input  logic                       clear_req,
   output logic                       busy,
   output logic                       clear_done,
   output logic                       conflict,
   input  logic                       conflict_clr,
   output logic [CNT_W-1:0]           conflict_cnt
);

   localparam int BYTES = DATA / LANE_W;
   localparam int DEPTH = 2 ** ADDR;

   logic [DATA-1:0]         mem [DEPTH];
   clr_state_t              state, state_nxt;
   logic [ADDR-1:0]         ptr;
   logic [NPORTS-1:0]       act, act_wr;
   logic [NPORTS*DATA-1:0]  merged, rd_word, s1_data;
   logic [NPORTS*BYTES-1:0] mask;
   logic [NPORTS-1:0]       s1_valid;
   logic                    wconflict;

   assign act    = en & {NPORTS{~busy}};
   assign act_wr = act & wr;

   mp_memory_wmerge #(.DATA(DATA), .ADDR(ADDR), .NPORTS(NPORTS)) u_wmerge (
      .act_wr   (act_wr),
      .be       (be),
      .addr     (addr),
      .din      (din),
      .merged   (merged),
      .mask     (mask),
      .conflict (wconflict)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              ptr <= '0;
      else if (state == CLEAR) ptr <= ptr + ADDR'(1);
      else                     ptr <= '0;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (clear_req) state_nxt = CLEAR;
         CLEAR:   if (ptr == '1) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy       = 1'b0;
      clear_done = 1'b0;
      case (state)
         CLEAR:   busy       = 1'b1;
         DONE:    clear_done = 1'b1;
         default: ;
      endcase
   end

   // Storage is deliberately left out of reset; the clear engine owns initialisation.
   always_ff @(posedge clk) begin
      if (state == CLEAR) mem[ptr] <= '0;
      for (int p = 0; p < NPORTS; p++) begin
         if (act_wr[p]) begin
            for (int b = 0; b < BYTES; b++) begin
               if (mask[p*BYTES + b])
                  mem[addr[p*ADDR +: ADDR]][b*LANE_W +: LANE_W] <= merged[p*DATA + b*LANE_W +: LANE_W];
            end
         end
      end
   end

   always_comb begin
      rd_word = '0;
      for (int p = 0; p < NPORTS; p++) begin
         rd_word[p*DATA +: DATA] = mem[addr[p*ADDR +: ADDR]];
         if (WRITE_FIRST != 0) begin
            for (int b = 0; b < BYTES; b++) begin
               if (mask[p*BYTES + b])
                  rd_word[p*DATA + b*LANE_W +: LANE_W] = merged[p*DATA + b*LANE_W +: LANE_W];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_data  <= '0;
         s1_valid <= '0;
      end else begin
         for (int p = 0; p < NPORTS; p++) begin
            s1_valid[p] <= act[p];
            if (act[p]) s1_data[p*DATA +: DATA] <= rd_word[p*DATA +: DATA];
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [NPORTS*DATA-1:0] s2_data;
         logic [NPORTS-1:0]      s2_valid;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s2_data  <= '0;
               s2_valid <= '0;
            end else begin
               for (int p = 0; p < NPORTS; p++) begin
                  s2_valid[p] <= s1_valid[p];
                  if (s1_valid[p]) s2_data[p*DATA +: DATA] <= s1_data[p*DATA +: DATA];
               end
            end
         end

         assign dout   = s2_data;
         assign dvalid = s2_valid;
      end else begin : g_no_out_reg
         assign dout   = s1_data;
         assign dvalid = s1_valid;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict     <= 1'b0;
         conflict_cnt <= '0;
      end else if (conflict_clr) begin
         conflict     <= 1'b0;
         conflict_cnt <= '0;
      end else if (wconflict) begin
         conflict <= 1'b1;
         if (conflict_cnt != '1) conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
   end

endmodule
